// File: rtl/intc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : intc_pkg                                                  |
// | Purpose   : Shared constants and types for the interrupt controller:  |
// |             IRQ bit indices, default IF/IE register addresses and     |
// |             the acknowledge FSM state encoding.                       |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package intc_pkg;

  localparam int NUM_IRQ_DEF = 5;

  // Interrupt source bit positions; bit 0 has the highest priority.
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [15:0] IF_ADDR_DEF = 16'hFF0F;
  localparam logic [15:0] IE_ADDR_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } ack_state_e;

endpackage
`default_nettype wire

// File: rtl/intc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : intc_if                                                   |
// | Purpose   : CPU memory-bus view of the interrupt controller.          |
// |   i_Address  16  CPU memory address                                   |
// |   i_Bus       8  CPU write data                                       |
// |   i_Bus_Out   1  CPU is writing this cycle                            |
// |   i_Bus_In    1  CPU is reading this cycle                            |
// |   o_Bus       8  read data, zero when the controller is not selected  |
// |   master = CPU side, slave = controller side                          |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface intc_if;
  logic [15:0] i_Address;
  logic [7:0]  i_Bus;
  logic        i_Bus_Out;
  logic        i_Bus_In;
  logic [7:0]  o_Bus;

  modport master (output i_Address, i_Bus, i_Bus_Out, i_Bus_In, input o_Bus);
  modport slave  (input i_Address, i_Bus, i_Bus_Out, i_Bus_In, output o_Bus);
endinterface
`default_nettype wire

// File: rtl/lsb_priority_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : lsb_priority_encoder                                      |
// | Purpose   : Returns the index of the lowest set bit of a vector.      |
// |   vec_i    WIDTH  input vector                                        |
// |   idx_o    IDX_W  index of lowest set bit (0 when none set)           |
// |   valid_o  1      at least one bit set                                |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module lsb_priority_encoder #(
  parameter int WIDTH = 5,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top down so the lowest set bit is the last to assign.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : interrupt_controller                                      |
// | Purpose   : Owns IF/IE, latches peripheral requests into IF, drives   |
// |             the CPU interrupt input with IF & IE and acknowledges the |
// |             highest-priority pending source when the CPU services it. |
// |   i_Clk, i_Rst (sync, active-high), i_Enable (clock enable)           |
// |   i_Requests          NUM_IRQ  peripheral request lines               |
// |   bus                 intc_if.slave  CPU read/write port              |
// |   i_Handle_Interrupt  1        CPU is servicing an interrupt          |
// |   o_Interrupts        NUM_IRQ  IF & IE                                |
// |   o_Ack_Valid         1        one-cycle acknowledge pulse            |
// |   o_Ack_Index         3        last acknowledged source               |
// | Config    : INTC_EDGE_DETECT_EN defined -> rising-edge request        |
// |             capture; undefined -> level-sensitive capture.            |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int          NUM_IRQ = NUM_IRQ_DEF,
  parameter logic [15:0] IF_ADDR = IF_ADDR_DEF,
  parameter logic [15:0] IE_ADDR = IE_ADDR_DEF
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Enable,
  input  logic [NUM_IRQ-1:0] i_Requests,
  intc_if.slave              bus,
  input  logic               i_Handle_Interrupt,
  output logic [NUM_IRQ-1:0] o_Interrupts,
  output logic               o_Ack_Valid,
  output logic [2:0]         o_Ack_Index
);

  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic [2:0]         ack_idx_q, ack_idx_d;
  ack_state_e         state_q, state_d;

  logic [NUM_IRQ-1:0] req_set;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [2:0]         sel;
  logic               sel_valid;
  logic               wr_if, wr_ie;
  logic [7:0]         rd_data;

`ifdef INTC_EDGE_DETECT_EN
  // Request history advances only on enabled cycles, so an edge that
  // spans disabled cycles is still seen on the next enabled one.
  logic [NUM_IRQ-1:0] req_hist_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      req_hist_q <= '0;
    end else if (i_Enable) begin
      req_hist_q <= i_Requests;
    end
  end

  assign req_set = i_Requests & ~req_hist_q;
`else
  assign req_set = i_Requests;
`endif

  assign o_Interrupts = if_q & ie_q[NUM_IRQ-1:0];

  lsb_priority_encoder #(
    .WIDTH (NUM_IRQ),
    .IDX_W (3)
  ) u_prio (
    .vec_i   (o_Interrupts),
    .idx_o   (sel),
    .valid_o (sel_valid)
  );

  assign wr_if = i_Enable & bus.i_Bus_Out & (bus.i_Address == IF_ADDR);
  assign wr_ie = i_Enable & bus.i_Bus_Out & (bus.i_Address == IE_ADDR);

  always_comb begin
    state_d     = state_q;
    ack_idx_d   = ack_idx_q;
    ack_clr     = '0;
    if_d        = if_q;
    ie_d        = ie_q;
    o_Ack_Valid = (state_q == ACK);

    if (i_Enable) begin
      unique case (state_q)
        IDLE: begin
          if (i_Handle_Interrupt && sel_valid) begin
            state_d   = ACK;
            ack_idx_d = sel;
            ack_clr   = NUM_IRQ'(1) << sel;
          end
        end
        ACK:  state_d = WAIT;
        WAIT: begin
          if (!i_Handle_Interrupt) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // Applied lowest priority first: CPU write, then ack clear, then
      // new request, so a fresh request always survives.
      if (wr_if) begin
        if_d = bus.i_Bus[NUM_IRQ-1:0];
      end
      if_d = (if_d & ~ack_clr) | req_set;

      if (wr_ie) begin
        ie_d = bus.i_Bus;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      if_q      <= '0;
      ie_q      <= '0;
      ack_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      if_q      <= if_d;
      ie_q      <= ie_d;
      ack_idx_q <= ack_idx_d;
    end
  end

  assign o_Ack_Index = ack_idx_q;

  // Unimplemented IF bits read as 1; zero output when not selected lets
  // the read data be OR-combined onto the shared bus.
  always_comb begin
    rd_data = '0;
    if (bus.i_Bus_In) begin
      if (bus.i_Address == IF_ADDR) begin
        rd_data = {{(8 - NUM_IRQ){1'b1}}, if_q};
      end else if (bus.i_Address == IE_ADDR) begin
        rd_data = ie_q;
      end
    end
  end

  assign bus.o_Bus = rd_data;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_interrupt_controller                                   |
// | Purpose   : Self-checking bench for interrupt_controller: directed    |
// |             scenarios with literal expectations plus randomized       |
// |             traffic compared each cycle against a behavioural model.  |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_interrupt_controller;
  import intc_pkg::*;

`ifdef INTC_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  localparam logic [15:0] IFA = 16'hFF0F;
  localparam logic [15:0] IEA = 16'hFFFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [4:0] req = '0;
  logic       hdl = 1'b0;
  logic [4:0] ints;
  logic       ack_v;
  logic [2:0] ack_i;

  intc_if bus_if ();

  interrupt_controller dut (
    .i_Clk              (clk),
    .i_Rst              (rst),
    .i_Enable           (en),
    .i_Requests         (req),
    .bus                (bus_if),
    .i_Handle_Interrupt (hdl),
    .o_Interrupts       (ints),
    .o_Ack_Valid        (ack_v),
    .o_Ack_Index        (ack_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [4:0] m_if, m_prev;
  logic [7:0] m_ie;
  logic       m_valid, m_blocked;
  logic [2:0] m_idx;
  bit         started = 1'b0;

  function automatic logic [4:0] lowest_bit(input logic [4:0] v);
    return v & (~v + 5'd1);
  endfunction

  function automatic logic [2:0] bit_index(input logic [4:0] onehot);
    return 3'($countones(onehot - 5'd1));
  endfunction

  // Acknowledge is possible when no pulse is in flight, the handle signal
  // has been released since the last acknowledge, and something is pending.
  function automatic bit ack_now(input logic hd, input logic v, input logic b, input logic [4:0] pend);
    return hd && !v && !b && (pend != 0);
  endfunction

  function automatic logic [4:0] next_if(input logic [4:0] cur, input logic [4:0] pend,
                                         input bit ack, input bit wr, input logic [7:0] wd,
                                         input logic [4:0] rq, input logic [4:0] prev);
    logic [4:0] n;
    n = wr ? wd[4:0] : cur;
    if (ack) n = n & ~lowest_bit(pend);
    n = n | (EDGE ? (rq & ~prev) : rq);
    return n;
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_if <= '0; m_ie <= '0; m_prev <= '0;
      m_valid <= 1'b0; m_blocked <= 1'b0; m_idx <= '0;
    end else if (en) begin
      m_prev <= req;
      if (bus_if.i_Bus_Out && bus_if.i_Address == IEA) m_ie <= bus_if.i_Bus;
      m_if <= next_if(m_if, m_if & m_ie[4:0],
                      ack_now(hdl, m_valid, m_blocked, m_if & m_ie[4:0]),
                      bus_if.i_Bus_Out && bus_if.i_Address == IFA, bus_if.i_Bus, req, m_prev);
      if (ack_now(hdl, m_valid, m_blocked, m_if & m_ie[4:0])) begin
        m_valid <= 1'b1;
        m_idx   <= bit_index(lowest_bit(m_if & m_ie[4:0]));
      end else if (m_valid) begin
        m_valid   <= 1'b0;
        m_blocked <= 1'b1;
      end else if (m_blocked && !hdl) begin
        m_blocked <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      check("ints", ints, m_if & m_ie[4:0]);
      check("ack_valid", ack_v, m_valid);
      check("ack_index", ack_i, m_idx);
      check("rdata", bus_if.o_Bus,
            !bus_if.i_Bus_In ? 8'h00 :
            (bus_if.i_Address == IFA) ? {3'b111, m_if} :
            (bus_if.i_Address == IEA) ? m_ie : 8'h00);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_if.i_Bus_Out = 1'b1;
    bus_if.i_Address = a;
    bus_if.i_Bus     = d;
    cyc();
    bus_if.i_Bus_Out = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    bus_if.i_Bus_In  = 1'b1;
    bus_if.i_Address = a;
    #1;
    check(name, bus_if.o_Bus, exp);
  endtask

  initial begin
    int nacks;
    bus_if.i_Address = '0;
    bus_if.i_Bus     = '0;
    bus_if.i_Bus_Out = 1'b0;
    bus_if.i_Bus_In  = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    check("rst_ints", ints, 5'h00);
    check("rst_ack_valid", ack_v, 1'b0);
    check("rst_ack_index", ack_i, 3'd0);
    check("rst_bus_idle", bus_if.o_Bus, 8'h00);
    rd_check("rst_if_read", IFA, 8'hE0);

    // Single-cycle request pulse on Timer
    wr(IEA, 8'h1F);
    req = 5'b1 << IRQ_TIMER;
    cyc();
    req = '0;
    check("pulse_ints", ints, 5'b00100);
    rd_check("pulse_if_read", IFA, 8'hE4);

    // Held handle acknowledges once, lowest pending first
    wr(IFA, 8'h0A);
    wr(IEA, 8'h0F);
    hdl = 1'b1;
    nacks = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (ack_v) begin
        nacks++;
        check("held_ack_index", ack_i, 3'(IRQ_STAT));
      end
    end
    check("held_ack_count", nacks, 1);
    rd_check("held_if_read", IFA, 8'hE8);
    hdl = 1'b0;
    cyc();
    hdl = 1'b1;
    cyc();
    check("reack_valid", ack_v, 1'b1);
    check("reack_index", ack_i, 3'(IRQ_SERIAL));
    hdl = 1'b0;
    cyc(); cyc();
    rd_check("reack_if_read", IFA, 8'hE0);

    // Everything masked: no acknowledge
    wr(IEA, 8'h00);
    wr(IFA, 8'h1F);
    hdl = 1'b1;
    cyc(); cyc();
    check("masked_ack_valid", ack_v, 1'b0);
    check("masked_ints", ints, 5'h00);
    rd_check("masked_if_read", IFA, 8'hFF);
    hdl = 1'b0;
    cyc();

    // Request edge beats a same-cycle IF write
    req = 5'b1 << IRQ_VBLANK;
    wr(IFA, 8'h00);
    req = '0;
    rd_check("edge_vs_write", IFA, 8'hE1);

    // Held Joypad request
    req = 5'b1 << IRQ_JOYPAD;
    wr(IFA, 8'h00);
    rd_check("hold_first", IFA, 8'hF0);
    cyc(); cyc(); cyc(); cyc();
    rd_check("hold_mid", IFA, 8'hF0);
    wr(IFA, 8'h00);
    rd_check("hold_after_clear", IFA, EDGE ? 8'hE0 : 8'hF0);
    cyc(); cyc(); cyc();
    rd_check("hold_later", IFA, EDGE ? 8'hE0 : 8'hF0);
    req = '0;
    cyc();

    // Reset during WAIT
    wr(IEA, 8'h1F);
    wr(IFA, 8'h01);
    hdl = 1'b1;
    cyc();
    check("wait_ack_valid", ack_v, 1'b1);
    cyc();
    check("wait_no_pulse", ack_v, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rd_check("wrst_if_read", IFA, 8'hE0);
    rd_check("wrst_ie_read", IEA, 8'h00);
    check("wrst_ack_valid", ack_v, 1'b0);
    check("wrst_ints", ints, 5'h00);
    wr(IEA, 8'h01);
    wr(IFA, 8'h01);
    cyc();
    check("wrst_idle_ack", ack_v, 1'b1);
    check("wrst_idle_index", ack_i, 3'(IRQ_VBLANK));
    hdl = 1'b0;
    cyc(); cyc();

    // Randomized traffic, checked by the per-cycle compare
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) req = req ^ (5'b1 << $urandom_range(0, 4));
      if ($urandom_range(0, 4) == 0) hdl = ~hdl;
      bus_if.i_Bus_Out = ($urandom_range(0, 4) == 0);
      bus_if.i_Bus_In  = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 3))
        0: bus_if.i_Address = IFA;
        1: bus_if.i_Address = IEA;
        2: bus_if.i_Address = 16'hFF0E;
        default: bus_if.i_Address = 16'($urandom);
      endcase
      bus_if.i_Bus = 8'($urandom);
      cyc();
    end
    rst = 1'b0;
    en  = 1'b1;
    bus_if.i_Bus_Out = 1'b0;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interrupt_controller.md
# interrupt_controller

Owns the IF (0xFF0F) and IE (0xFFFF) registers and sits directly upstream of the CPU. It latches peripheral interrupt requests into IF and presents the masked pending set (IF & IE) on the CPU's interrupt input. When the CPU signals that it is handling an interrupt, the block acknowledges the highest-priority pending source by clearing its IF bit. It also answers CPU reads and writes to IF/IE on the shared 8-bit bus, contributing zero when not selected so its output can be OR-combined onto the data bus.

## Interface
- NUM_IRQ, 5, number of interrupt sources (VBlank, STAT, Timer, Serial, Joypad; bit 0 highest priority)
- IF_ADDR, 16'hFF0F, address of the interrupt flag register
- IE_ADDR, 16'hFFFF, address of the interrupt enable register

- i_Clk  in  1  system clock; one clock domain; reset is synchronous and active-high
- i_Rst  in  1  synchronous reset, active-high
- i_Enable  in  1  clock enable; all state advances only when high
- i_Requests  in  NUM_IRQ  peripheral request lines
- i_Address  in  16  CPU memory address
- i_Bus  in  8  CPU write data
- i_Bus_Out  in  1  CPU is writing memory this cycle
- i_Bus_In  in  1  CPU is reading memory this cycle
- i_Handle_Interrupt  in  1  CPU is servicing an interrupt
- o_Interrupts  out  NUM_IRQ  IF & IE[NUM_IRQ-1:0], drives the CPU's interrupt input
- o_Bus  out  8  read data; 0 when not selected
- o_Ack_Valid  out  1  one-cycle pulse when a source is acknowledged
- o_Ack_Index  out  3  index of the last acknowledged source

## Operation
- **Reset values:** IF=0, IE=0, all request history=0, FSM=IDLE, o_Ack_Valid=0, o_Ack_Index=0, o_Interrupts=0, o_Bus=0.
- **Request capture:** a rising edge on i_Requests[n] (0 last enabled cycle, 1 now) sets IF[n]. The edge history updates only on enabled cycles.
- **CPU write:** when i_Enable & i_Bus_Out and i_Address==IF_ADDR, IF <= i_Bus[NUM_IRQ-1:0]. When the address is IE_ADDR, IE <= i_Bus (all 8 bits stored).
- **CPU read (combinational):**
  - IF_ADDR: o_Bus = {3'b111, IF}.
  - IE_ADDR: o_Bus = IE.
  - Otherwise, or when i_Bus_In is low: o_Bus = 0.
- **Acknowledge FSM:**
  - IDLE -> ACK when i_Handle_Interrupt is high and o_Interrupts != 0. In the same cycle, sel = lowest set bit of o_Interrupts; IF[sel] is cleared; o_Ack_Index <= sel.
  - ACK: o_Ack_Valid=1 for exactly this cycle; then -> WAIT.
  - WAIT -> IDLE when i_Handle_Interrupt is low. A held handle signal therefore acknowledges only once.
  - If i_Handle_Interrupt rises with o_Interrupts==0, the FSM stays in IDLE and nothing is cleared.
- **Same-cycle priority per IF bit (highest first):** new request edge, then ack clear, then CPU write. A new edge on a bit being acknowledged leaves that bit set.
- **Bits without effect:** IE bits 7:5 are stored and read back but never mask anything.

## Timing
- Request edge at cycle t: IF set at t+1; o_Interrupts reflects it at t+1 if enabled in IE.
- Register write at t: visible on o_Interrupts and on read at t+1.
- Handle asserted at t (IDLE): IF bit cleared and o_Ack_Index updated at t+1; o_Ack_Valid high during t+1 only.
- i_Enable low: every register holds, and a request edge spanning disabled cycles is detected on the next enabled cycle.
- Reset mid-ACK or mid-WAIT: the FSM returns to IDLE and pending state is discarded.

## Configuration
- Macro: INTC_EDGE_DETECT_EN.
- **Defined:** request capture is rising-edge detected as described above.
- **Undefined:** capture is level sensitive; IF[n] is set on every enabled cycle that i_Requests[n] is high, and the request history registers are removed.

## Structure
- **intc_pkg** holds:
  - IRQ bit index constants (IRQ_VBLANK=0, IRQ_STAT=1, IRQ_TIMER=2, IRQ_SERIAL=3, IRQ_JOYPAD=4)
  - IF_ADDR/IE_ADDR defaults
  - the ack FSM state encoding (IDLE, ACK, WAIT)
- **Sub-module:** lsb_priority_encoder, which takes the NUM_IRQ-bit vector and produces an index plus a valid flag.

## Test plan
- Write IE=0x1F. Pulse i_Requests[2] for 1 cycle -> IF read returns 0xE4 and o_Interrupts=5'b00100 the next cycle.
- IF=0x0A, IE=0x0F, raise i_Handle_Interrupt and hold it 4 cycles -> one o_Ack_Valid pulse with o_Ack_Index=1; IF=0x08; no second ack until handle drops and re-rises (then index 3).
- IE=0x00 with IF=0x1F, raise handle -> no ack, IF unchanged, o_Interrupts=0.
- In the same cycle, write IF=0x00 and apply a rising edge on request 0 -> IF=0x01.
- Hold i_Requests[4] high 10 cycles -> IF[4] is set once; after a CPU write clears it, it stays 0 (edge build). In a level build, IF[4] is set again the next cycle.
- Assert i_Rst during WAIT -> IF=0, IE=0, o_Bus reads 0xE0 at IF_ADDR, FSM in IDLE, o_Ack_Valid=0.
